serial_magnitude_comparator: RTL

- Compares two WIDTH-bit unsigned operands serially, MSB first, examining one 2-bit slice per clock.
- Produces registered gt/eq/lt flags with a start/busy/done handshake.
- Sits downstream of the team's combinational 2-bit comparator stage, which it instantiates as its per-slice decision element.
- Used where a full-width combinational comparator is too costly in area.

---
 rtl/serial_magnitude_comparator_pkg.sv | 23 ++
 rtl/serial_magnitude_comparator_if.sv | 25 ++
 rtl/serial_magnitude_comparator_slice.sv | 16 +
 rtl/serial_magnitude_comparator.sv | 137 +++++++++++++
 4 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator.
//   state_t   : FSM state encoding (IDLE, COMPARE, DONE)
//   result_t  : registered comparison result, ordered {gt, eq, lt}
//   cnt_width : slice-counter width for a given slice count (minimum 1 bit)
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } result_t;

  function automatic int cnt_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle for the serial magnitude comparator.
//   start, a, b             : request side, driven by the requester (master)
//   busy, done, gt, eq, lt  : status/result side, driven by the comparator (slave)
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/serial_magnitude_comparator_slice.sv
// Combinational 2-bit unsigned comparator used as the per-slice decision
// element of the serial comparator.
//   x, y     : 2-bit slices under comparison
//   slice_gt : x > y
//   slice_lt : x < y   (equality is implied when both outputs are 0)
module slice_compare_2bit (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       slice_gt,
  output logic       slice_lt
);

  assign slice_gt = (x > y);
  assign slice_lt = (x < y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: examines one 2-bit slice per clock,
// MSB first, and exits on the first differing slice.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_magnitude_comparator_if
//           start/a/b in; busy/done/gt/eq/lt out (all outputs registered)
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_magnitude_comparator_if.slave  bus
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = cnt_width(NSLICE);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_magnitude_comparator: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  result_t          res;
  logic             busy_q;
  logic             done_q;
  logic             busy_d;
  logic             done_d;
  logic             slice_gt;
  logic             slice_lt;
  logic             last_slice;

  // The top slice of each shift register is always the one under test.
  slice_compare_2bit u_slice (
    .x        (sa[WIDTH-1 -: 2]),
    .y        (sb[WIDTH-1 -: 2]),
    .slice_gt (slice_gt),
    .slice_lt (slice_lt)
  );

  assign last_slice = (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (slice_gt || slice_lt || last_slice) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: busy/done are decoded from the state being entered so the
  // registered copies line up exactly with the state itself.
  always_comb begin
    busy_d = (state_nxt != IDLE);
    done_d = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Datapath: operand capture, slice shifting, counter and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            cnt <= CW'(NSLICE - 1);
            res <= '0;
          end
        end
        COMPARE: begin
          if (slice_gt) begin
            res <= '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
          end else if (slice_lt) begin
            res <= '{gt: 1'b0, eq: 1'b0, lt: 1'b1};
          end else if (last_slice) begin
            res <= '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
          end else begin
            // Equal so far: bring the next slice up to the top.
            sa  <= sa << 2;
            sb  <= sb << 2;
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = res.gt;
  assign bus.eq   = res.eq;
  assign bus.lt   = res.lt;

endmodule
